// File: rtl/gon_mcast_buffered_ctrl.sv
// Buffered multicast tap for the GON X/Y buses: tag/ID/mask match with optional
// broadcast, accepted payloads queued in a first-word-fall-through FIFO toward the PE.
module gon_mcast_buffered_ctrl #(
  parameter int unsigned ID_LEN    = 4,
  parameter int unsigned VALUE_LEN = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_LEN   = 16,
  parameter bit          BCAST_EN  = 1'b1,
  parameter int unsigned MA_X      = 0,
  parameter int unsigned MA_Y      = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               set_id,
  input  logic [ID_LEN-1:0]                  id_in,
  input  logic [ID_LEN-1:0]                  mask_in,
  output logic [ID_LEN-1:0]                  id,
  output logic [ID_LEN-1:0]                  mask,
  input  logic [ID_LEN-1:0]                  tag,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic                               hit,
  input  logic [VALUE_LEN-1:0]               value_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [VALUE_LEN-1:0]               value_out,
  output logic [$clog2(DEPTH+1)-1:0]         level,
  output logic [CNT_LEN-1:0]                 pkt_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH+1);

  logic [VALUE_LEN-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 tag_match;
  logic                 bcast;

  // Machine address is carried for debug visibility only.
  logic [63:0] unused_ma;
  assign unused_ma = {32'(MA_X), 32'(MA_Y)};

  // Destination match; a non-target never stalls the shared bus.
  assign tag_match = (((tag ^ id) & mask) == '0);
  assign bcast     = BCAST_EN && (&tag);
  assign hit       = tag_match | bcast;
  assign full      = (level == LVL_W'(DEPTH));
  assign in_ready  = ~set_id & (~hit | ~full);
  assign push      = in_valid & hit & ~full & ~set_id;

  assign out_valid = (level != '0);
  assign pop       = out_valid & out_ready;
  assign value_out = out_valid ? mem[rd_ptr] : '0;

  // ID and group mask; reset to exact match on ID 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      id   <= '0;
      mask <= '1;
    end else if (set_id) begin
      id   <= id_in;
      mask <= mask_in;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= value_in;
  end

  // Saturating accepted-packet counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else if (push && (pkt_cnt != '1)) begin
      pkt_cnt <= pkt_cnt + CNT_LEN'(1);
    end
  end

endmodule

// File: tb/tb_gon_mcast_buffered_ctrl.sv
// Directed bench for gon_mcast_buffered_ctrl: a main instance with a scoreboard,
// a group peer, and a broadcast-disabled instance with a narrow counter.
module tb_gon_mcast_buffered_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [3:0]  tag;
  logic [31:0] value_in;

  logic        set_id_a, set_id_p, set_id_n;
  logic [3:0]  id_in_a, id_in_p, id_in_n;
  logic [3:0]  mask_in_a, mask_in_p, mask_in_n;
  logic        out_ready_a, out_ready_p, out_ready_n;

  logic [3:0]  id_a, id_p, id_n, mask_a, mask_p, mask_n;
  logic        in_ready_a, in_ready_p, in_ready_n;
  logic        hit_a, hit_p, hit_n;
  logic        out_valid_a, out_valid_p, out_valid_n;
  logic [31:0] value_out_a, value_out_p, value_out_n;
  logic [2:0]  level_a, level_p, level_n;
  logic [15:0] pkt_cnt_a, pkt_cnt_p;
  logic [1:0]  pkt_cnt_n;

  logic [31:0] exp_q[$];
  int total;
  int bad;

  gon_mcast_buffered_ctrl #(.DEPTH(4), .BCAST_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .set_id(set_id_a), .id_in(id_in_a), .mask_in(mask_in_a),
    .id(id_a), .mask(mask_a), .tag(tag), .in_valid(in_valid), .in_ready(in_ready_a),
    .hit(hit_a), .value_in(value_in), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .value_out(value_out_a), .level(level_a), .pkt_cnt(pkt_cnt_a));

  gon_mcast_buffered_ctrl #(.DEPTH(4), .BCAST_EN(1'b1)) u_peer (
    .clk(clk), .rst(rst), .set_id(set_id_p), .id_in(id_in_p), .mask_in(mask_in_p),
    .id(id_p), .mask(mask_p), .tag(tag), .in_valid(in_valid), .in_ready(in_ready_p),
    .hit(hit_p), .value_in(value_in), .out_valid(out_valid_p), .out_ready(out_ready_p),
    .value_out(value_out_p), .level(level_p), .pkt_cnt(pkt_cnt_p));

  gon_mcast_buffered_ctrl #(.DEPTH(4), .BCAST_EN(1'b0), .CNT_LEN(2)) u_nob (
    .clk(clk), .rst(rst), .set_id(set_id_n), .id_in(id_in_n), .mask_in(mask_in_n),
    .id(id_n), .mask(mask_n), .tag(tag), .in_valid(in_valid), .in_ready(in_ready_n),
    .hit(hit_n), .value_in(value_in), .out_valid(out_valid_n), .out_ready(out_ready_n),
    .value_out(value_out_n), .level(level_n), .pkt_cnt(pkt_cnt_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Scoreboard: every pop of the main instance must match the oldest accepted value.
  always @(negedge clk) begin
    if (!rst && out_valid_a && out_ready_a) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_underflow observed=%h expected=none", value_out_a);
      end else begin
        chk("sb_data", value_out_a, exp_q.pop_front());
      end
    end
  end

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; in_valid = 1'b0; tag = 4'h0; value_in = '0;
    set_id_a = 1'b0; set_id_p = 1'b0; set_id_n = 1'b0;
    id_in_a = '0; id_in_p = '0; id_in_n = '0;
    mask_in_a = '0; mask_in_p = '0; mask_in_n = '0;
    out_ready_a = 1'b0; out_ready_p = 1'b0; out_ready_n = 1'b0;
    step(); step();
    rst = 1'b0;
    neg();
    chk("rst_level", 32'(level_a), 32'd0);
    chk("rst_out_valid", 32'(out_valid_a), 32'd0);
    chk("rst_value_out", value_out_a, 32'd0);
    chk("rst_pkt_cnt", 32'(pkt_cnt_a), 32'd0);
    chk("rst_id", 32'(id_a), 32'd0);
    chk("rst_mask", 32'(mask_a), 32'hF);
    chk("rst_hit", 32'(hit_a), 32'd1);
    chk("rst_in_ready", 32'(in_ready_a), 32'd1);
    step();

    // set_id with a simultaneous offer: old id used, no push
    set_id_a = 1'b1; id_in_a = 4'd3; mask_in_a = 4'hF;
    in_valid = 1'b1; tag = 4'd3; value_in = 32'hDEADBEEF;
    neg();
    chk("setid_hit_old", 32'(hit_a), 32'd0);
    chk("setid_in_ready", 32'(in_ready_a), 32'd0);
    step();
    set_id_a = 1'b0; in_valid = 1'b0;
    neg();
    chk("setid_id", 32'(id_a), 32'd3);
    chk("setid_no_push", 32'(level_a), 32'd0);
    step();

    in_valid = 1'b1; tag = 4'd3; value_in = 32'hA5A5A5A5;
    neg();
    chk("t1_hit", 32'(hit_a), 32'd1);
    chk("t1_in_ready", 32'(in_ready_a), 32'd1);
    exp_q.push_back(32'hA5A5A5A5);
    step();
    in_valid = 1'b0;
    neg();
    chk("t1_out_valid", 32'(out_valid_a), 32'd1);
    chk("t1_value_out", value_out_a, 32'hA5A5A5A5);
    chk("t1_level", 32'(level_a), 32'd1);
    chk("t1_pkt_cnt", 32'(pkt_cnt_a), 32'd1);
    step();
    out_ready_a = 1'b1;
    neg();
    step();
    out_ready_a = 1'b0;
    neg();
    chk("t1_drained", 32'(level_a), 32'd0);
    step();

    // group multicast: id 5 and id 6 under mask 1100
    set_id_a = 1'b1; id_in_a = 4'd5; mask_in_a = 4'b1100;
    set_id_p = 1'b1; id_in_p = 4'd6; mask_in_p = 4'b1100;
    neg();
    step();
    set_id_a = 1'b0; set_id_p = 1'b0;
    in_valid = 1'b1; tag = 4'd4; value_in = 32'h44;
    neg();
    chk("grp_hit_a", 32'(hit_a), 32'd1);
    chk("grp_hit_p", 32'(hit_p), 32'd1);
    exp_q.push_back(32'h44);
    step();
    tag = 4'd8; value_in = 32'h88;
    neg();
    chk("grp_level_a", 32'(level_a), 32'd1);
    chk("grp_level_p", 32'(level_p), 32'd1);
    chk("grp_miss_hit_a", 32'(hit_a), 32'd0);
    chk("grp_miss_hit_p", 32'(hit_p), 32'd0);
    chk("grp_miss_rdy_a", 32'(in_ready_a), 32'd1);
    chk("grp_miss_rdy_p", 32'(in_ready_p), 32'd1);
    step();
    in_valid = 1'b0;
    neg();
    chk("grp_miss_level_a", 32'(level_a), 32'd1);
    chk("grp_miss_level_p", 32'(level_p), 32'd1);
    chk("grp_value_p", value_out_p, 32'h44);
    step();
    out_ready_a = 1'b1; out_ready_p = 1'b1;
    neg();
    step();
    out_ready_a = 1'b0; out_ready_p = 1'b0;
    neg();
    chk("grp_drained", 32'(level_a), 32'd0);
    step();

    // fill to DEPTH, then refuse a fifth
    set_id_a = 1'b1; id_in_a = 4'd2; mask_in_a = 4'hF;
    neg();
    step();
    set_id_a = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; tag = 4'd2; value_in = 32'(i);
      neg();
      exp_q.push_back(32'(i));
      step();
    end
    value_in = 32'd5;
    neg();
    chk("full_level", 32'(level_a), 32'd4);
    chk("full_hit", 32'(hit_a), 32'd1);
    chk("full_in_ready", 32'(in_ready_a), 32'd0);
    step();
    tag = 4'd8;
    neg();
    chk("full_level_hold", 32'(level_a), 32'd4);
    chk("full_pkt_cnt", 32'(pkt_cnt_a), 32'd6);
    chk("full_nontarget_rdy", 32'(in_ready_a), 32'd1);
    step();
    in_valid = 1'b0; tag = 4'd2; out_ready_a = 1'b1;
    neg();
    chk("pop_rdy_same_cycle", 32'(in_ready_a), 32'd0);
    step();
    out_ready_a = 1'b0;
    neg();
    chk("pop_rdy_next_cycle", 32'(in_ready_a), 32'd1);
    chk("pop_level", 32'(level_a), 32'd3);
    step();
    out_ready_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      neg();
      step();
    end
    out_ready_a = 1'b0;
    neg();
    chk("fill_drained", 32'(level_a), 32'd0);
    step();

    // simultaneous push and pop at level 2
    in_valid = 1'b1; tag = 4'd2;
    for (int i = 0; i < 2; i++) begin
      value_in = 32'(10 + i);
      neg();
      exp_q.push_back(32'(10 + i));
      step();
    end
    out_ready_a = 1'b1;
    for (int k = 0; k < 10; k++) begin
      value_in = 32'(12 + k);
      neg();
      chk("pp_level", 32'(level_a), 32'd2);
      exp_q.push_back(32'(12 + k));
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      neg();
      step();
    end
    out_ready_a = 1'b0;
    neg();
    chk("pp_drained", 32'(level_a), 32'd0);
    step();

    // broadcast accepted only where enabled
    set_id_n = 1'b1; id_in_n = 4'd2; mask_in_n = 4'hF;
    neg();
    step();
    set_id_n = 1'b0;
    in_valid = 1'b1; tag = 4'hF; value_in = 32'hBB;
    neg();
    chk("bc_hit_a", 32'(hit_a), 32'd1);
    chk("bc_hit_n", 32'(hit_n), 32'd0);
    chk("bc_rdy_n", 32'(in_ready_n), 32'd1);
    exp_q.push_back(32'hBB);
    step();
    in_valid = 1'b0;
    neg();
    chk("bc_level_a", 32'(level_a), 32'd1);
    chk("bc_level_n", 32'(level_n), 32'd0);
    step();

    // counter saturation on the 2-bit instance
    out_ready_a = 1'b1; out_ready_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; tag = 4'd2; value_in = 32'h30 + 32'(i);
      neg();
      exp_q.push_back(32'h30 + 32'(i));
      step();
    end
    in_valid = 1'b0;
    neg();
    step();
    out_ready_a = 1'b0; out_ready_n = 1'b0;
    neg();
    chk("sat_pkt_cnt_n", 32'(pkt_cnt_n), 32'd3);
    chk("sat_level_n", 32'(level_n), 32'd0);
    chk("sat_level_a", 32'(level_a), 32'd0);
    chk("sat_pkt_cnt_a", 32'(pkt_cnt_a), 32'd24);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    step();

    // reset mid-operation at level 3
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; tag = 4'd2; value_in = 32'h61 + 32'(i);
      neg();
      exp_q.push_back(32'h61 + 32'(i));
      step();
    end
    set_id_a = 1'b1; id_in_a = 4'd2; mask_in_a = 4'hF; value_in = 32'h64;
    neg();
    chk("setid2_in_ready", 32'(in_ready_a), 32'd0);
    step();
    set_id_a = 1'b0; in_valid = 1'b0;
    neg();
    chk("pre_rst_level", 32'(level_a), 32'd3);
    step();
    rst = 1'b1;
    neg();
    step();
    rst = 1'b0;
    exp_q.delete();
    neg();
    chk("mid_rst_level", 32'(level_a), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid_a), 32'd0);
    chk("mid_rst_value_out", value_out_a, 32'd0);
    chk("mid_rst_pkt_cnt", 32'(pkt_cnt_a), 32'd0);
    chk("mid_rst_id", 32'(id_a), 32'd0);
    chk("mid_rst_mask", 32'(mask_a), 32'hF);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
